// File: rtl/vehicle_sup_pkg.sv
// Shared types and helpers for the vehicle supervisor: FSM state encoding
// and a width-generic saturating increment.
package vehicle_sup_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    HALT   = 3'd2,
    NO_GAS = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Increment v, holding at the all-ones value of a w-bit field (w < 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_val;
    max_val = (64'd1 << w) - 64'd1;
    return (v >= max_val) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/overheat_debounce.sv
// Single-channel overheat debounce with assert/cool-down hysteresis.
// SHUTDOWN_LATCH_EN: shut-off latches until clr_fault while raw is low.
module overheat_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned COOL_CYC     = 8
) (
  input  logic clk,
  input  logic areset_n,
  input  logic raw,
  input  logic clr_fault,
  output logic shut_off
);

  localparam int unsigned MAX_CYC = (DEBOUNCE_CYC > COOL_CYC) ? DEBOUNCE_CYC : COOL_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  logic [CW-1:0] cnt;

  // cnt tracks consecutive samples that disagree with the current output.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cnt      <= '0;
      shut_off <= 1'b0;
    end else if (raw == shut_off) begin
      cnt <= '0;
    end else if (!shut_off) begin
      if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        shut_off <= 1'b1;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
`ifdef SHUTDOWN_LATCH_EN
      cnt <= '0;
      if (clr_fault) shut_off <= 1'b0;
`else
      if (cnt == CW'(COOL_CYC - 1)) begin
        shut_off <= 1'b0;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
`endif
    end
  end

`ifndef SHUTDOWN_LATCH_EN
  logic unused_clr_fault;
  assign unused_clr_fault = clr_fault;
`endif

endmodule

// File: rtl/vehicle_supervisor.sv
// Vehicle supervisor: per-CPU overheat debounce plus registered drive FSM.
// Optional SHUTDOWN_LATCH_EN makes shut-offs sticky until clr_fault.
module vehicle_supervisor
  import vehicle_sup_pkg::*;
#(
  parameter int unsigned NUM_CPU      = 2,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned COOL_CYC     = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               areset_n,
  input  logic [NUM_CPU-1:0] cpu_overheated,
  input  logic               arrived,
  input  logic               gas_tank_empty,
  input  logic               start,
  input  logic               clr_fault,
  output logic [NUM_CPU-1:0] shut_off_computer,
  output logic               shutdown_any,
  output logic               keep_driving,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   drive_cycles
);

  state_e state_q, state_d;

  for (genvar i = 0; i < NUM_CPU; i++) begin : g_deb
    overheat_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .COOL_CYC     (COOL_CYC)
    ) u_deb (
      .clk       (clk),
      .areset_n  (areset_n),
      .raw       (cpu_overheated[i]),
      .clr_fault (clr_fault),
      .shut_off  (shut_off_computer[i])
    );
  end

  // OR of the channel flops: changes on the same edge as the channel outputs.
  assign shutdown_any = |shut_off_computer;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start && !arrived && !gas_tank_empty && !shutdown_any) state_d = DRIVE;
      DRIVE: begin
        if (arrived)             state_d = DONE;
        else if (gas_tank_empty) state_d = NO_GAS;
        else if (shutdown_any)   state_d = HALT;
      end
      HALT: begin
        if (arrived)             state_d = DONE;
        else if (gas_tank_empty) state_d = NO_GAS;
        else if (!shutdown_any)  state_d = DRIVE;
      end
      NO_GAS: if (!gas_tank_empty) state_d = IDLE;
      DONE:   if (!arrived)        state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    keep_driving = (state_q == DRIVE);
    state        = state_q;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      drive_cycles <= '0;
    end else if (state_q == IDLE && state_d == DRIVE) begin
      drive_cycles <= '0;
    end else if (state_q == DRIVE) begin
      drive_cycles <= CNT_W'(sat_inc(64'(drive_cycles), CNT_W));
    end
  end

endmodule

// File: tb/tb_vehicle_supervisor.sv
// Directed self-checking bench for vehicle_supervisor (default parameters
// plus a CNT_W=4 instance for saturation), covers both latch-mode builds.
module tb_vehicle_supervisor;

  logic       clk = 1'b0;
  logic       areset_n;
  logic [1:0] cpu_overheated;
  logic       arrived, gas_tank_empty, start, clr_fault;

  logic [1:0]  shut_off_computer, sat_shut;
  logic        shutdown_any, sat_any;
  logic        keep_driving, sat_kd;
  logic [2:0]  state, sat_state;
  logic [15:0] drive_cycles;
  logic [3:0]  sat_cycles;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  vehicle_supervisor #(
    .NUM_CPU(2), .DEBOUNCE_CYC(4), .COOL_CYC(8), .CNT_W(16)
  ) u_dut (
    .clk(clk), .areset_n(areset_n), .cpu_overheated(cpu_overheated),
    .arrived(arrived), .gas_tank_empty(gas_tank_empty), .start(start),
    .clr_fault(clr_fault), .shut_off_computer(shut_off_computer),
    .shutdown_any(shutdown_any), .keep_driving(keep_driving),
    .state(state), .drive_cycles(drive_cycles)
  );

  vehicle_supervisor #(
    .NUM_CPU(2), .DEBOUNCE_CYC(4), .COOL_CYC(8), .CNT_W(4)
  ) u_dut_sat (
    .clk(clk), .areset_n(areset_n), .cpu_overheated(cpu_overheated),
    .arrived(arrived), .gas_tank_empty(gas_tank_empty), .start(start),
    .clr_fault(clr_fault), .shut_off_computer(sat_shut),
    .shutdown_any(sat_any), .keep_driving(sat_kd),
    .state(sat_state), .drive_cycles(sat_cycles)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    areset_n = 1'b0; cpu_overheated = 2'b00; arrived = 1'b0;
    gas_tank_empty = 1'b0; start = 1'b0; clr_fault = 1'b0;
    tick(2);
    check("rst_state", state, 0);
    check("rst_shut", shut_off_computer, 0);
    check("rst_any", shutdown_any, 0);
    check("rst_kd", keep_driving, 0);
    check("rst_cycles", drive_cycles, 0);
    areset_n = 1'b1;
    tick();

    // Short pulse below threshold, then exact threshold.
    cpu_overheated = 2'b01;
    tick(3);
    check("deb_3hi", shut_off_computer, 2'b00);
    cpu_overheated = 2'b00;
    tick();
    check("deb_drop", shut_off_computer, 2'b00);
    cpu_overheated = 2'b01;
    tick(3);
    check("deb_3hi_b", shut_off_computer, 2'b00);
    tick();
    check("deb_4hi", shut_off_computer, 2'b01);
    check("deb_any", shutdown_any, 1);

`ifdef SHUTDOWN_LATCH_EN
    cpu_overheated = 2'b00;
    tick(20);
    check("latch_hold", shut_off_computer, 2'b01);
    cpu_overheated = 2'b01; clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    check("latch_clr_hi", shut_off_computer, 2'b01);
    cpu_overheated = 2'b00; clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    check("latch_clr_lo", shut_off_computer, 2'b00);
`else
    // Cool-down restarts after a one-cycle glitch.
    cpu_overheated = 2'b00;
    tick(7);
    check("cool_7lo", shut_off_computer, 2'b01);
    cpu_overheated = 2'b01;
    tick();
    check("cool_glitch", shut_off_computer, 2'b01);
    cpu_overheated = 2'b00;
    tick(7);
    check("cool_7lo_b", shut_off_computer, 2'b01);
    tick();
    check("cool_8lo", shut_off_computer, 2'b00);
    check("cool_any", shutdown_any, 0);
`endif

    // Drive, overheat channel 1, resume.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("drv_state", state, 1);
    check("drv_kd", keep_driving, 1);
    check("drv_cyc0", drive_cycles, 0);
    tick(10);
    check("drv_cyc10", drive_cycles, 10);
    cpu_overheated = 2'b10;
    tick(4);
    check("ovh_shut", shut_off_computer, 2'b10);
    check("ovh_still_drive", state, 1);
    check("ovh_cyc14", drive_cycles, 14);
    tick();
    check("halt_state", state, 2);
    check("halt_kd", keep_driving, 0);
    check("halt_cyc", drive_cycles, 15);
    cpu_overheated = 2'b00;
`ifdef SHUTDOWN_LATCH_EN
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
`else
    tick(8);
`endif
    check("halt_released", shut_off_computer, 2'b00);
    check("halt_hold", state, 2);
    tick();
    check("resume_state", state, 1);
    check("resume_cyc", drive_cycles, 15);
    tick();
    check("resume_cyc16", drive_cycles, 16);
    tick(5);
    check("drive_cyc21", drive_cycles, 21);
    check("sat_cyc15", sat_cycles, 15);

    // Simultaneous arrived and empty: arrived wins.
    arrived = 1'b1; gas_tank_empty = 1'b1;
    tick();
    check("done_state", state, 4);
    check("done_kd", keep_driving, 0);
    arrived = 1'b0;
    tick();
    check("done_idle", state, 0);
    gas_tank_empty = 1'b0;

    start = 1'b1; arrived = 1'b1;
    tick();
    check("start_blocked", state, 0);
    arrived = 1'b0;
    tick();
    start = 1'b0;
    check("restart_state", state, 1);
    check("restart_cyc", drive_cycles, 0);
    gas_tank_empty = 1'b1;
    tick();
    check("nogas_state", state, 3);
    check("nogas_cyc", drive_cycles, 1);
    gas_tank_empty = 1'b0;
    tick();
    check("nogas_idle", state, 0);

    // Asynchronous reset mid-drive, checked between clock edges.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    check("pre_arst_cyc", drive_cycles, 2);
    #2 areset_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_kd", keep_driving, 0);
    check("arst_cyc", drive_cycles, 0);
    check("arst_sat_cyc", sat_cycles, 0);
    #1 areset_n = 1'b1;
    tick();
    check("post_arst_state", state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
